// File: rtl/crc_stim_gen.sv
// Stimulus generator and response checker for a downstream accumulator and pass-through buses.
// A 64-bit LFSR feeds replicated buses; echoes and accumulator responses are checked every RUN cycle.
module crc_stim_gen #(
  parameter logic [63:0] SEED         = 64'h5aef0c8d_d70a4497,
  parameter logic [31:0] ACCUM_BASE   = 32'd0,
  parameter logic [31:0] ACCUM_STEP   = 32'd5,
  parameter logic [31:0] SECRET_VALUE = 32'd7,
  parameter int unsigned NUM_CYCLES   = 10,
  parameter int unsigned BYPASS_CYC   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [31:0]  accum_in,
  output logic         accum_bypass,
  output logic         s1_in,
  output logic [1:0]   s2_in,
  output logic [7:0]   s8_in,
  output logic [32:0]  s33_in,
  output logic [63:0]  s64_in,
  output logic [64:0]  s65_in,
  output logic [128:0] s129_in,
  output logic [127:0] s4x32_in,
  input  logic [31:0]  accum_out,
  input  logic [31:0]  accum_bypass_out,
  input  logic         s1_out,
  input  logic [1:0]   s2_out,
  input  logic [7:0]   s8_out,
  input  logic [32:0]  s33_out,
  input  logic [63:0]  s64_out,
  input  logic [64:0]  s65_out,
  input  logic [128:0] s129_out,
  input  logic [127:0] s4x32_out,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [7:0]   err_count
);

  localparam int NUM_CHECKS = 10;
  localparam logic [15:0] LAST_IDX   = 16'(NUM_CYCLES - 1);
  localparam logic [15:0] BYPASS_IDX = 16'(BYPASS_CYC);

  if (NUM_CYCLES < 2 || NUM_CYCLES > 65535) begin : g_bad_num_cycles
    $error("crc_stim_gen: NUM_CYCLES must lie in 2..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t      state_reg;
  logic [63:0] crc_reg;
  logic [31:0] accum_in_reg;
  logic        accum_bypass_reg;
  logic [15:0] run_idx_reg;
  logic [31:0] prev_out_reg;
  logic [31:0] prev_in_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        err_reg;
  logic [7:0]  err_count_reg;

  logic [NUM_CHECKS-1:0] mism_vec;
  logic [3:0]            mism_cnt;
  logic [8:0]            err_sum;
  logic [7:0]            err_count_next;

  // Every bus is a replication of the LFSR state cut down to its own width.
  assign s1_in    = crc_reg[0];
  assign s2_in    = crc_reg[1:0];
  assign s8_in    = crc_reg[7:0];
  assign s33_in   = crc_reg[32:0];
  assign s64_in   = crc_reg;
  assign s65_in   = {crc_reg[0], crc_reg};
  assign s129_in  = {crc_reg[0], crc_reg, crc_reg};
  assign s4x32_in = {crc_reg, crc_reg};

  assign accum_in     = accum_in_reg;
  assign accum_bypass = accum_bypass_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign err_count    = err_count_reg;

  // One flag per independent check; all flags raised in a cycle are counted together.
  always_comb begin
    mism_vec    = '0;
    mism_vec[0] = (s1_out    != s1_in);
    mism_vec[1] = (s2_out    != s2_in);
    mism_vec[2] = (s8_out    != s8_in);
    mism_vec[3] = (s33_out   != s33_in);
    mism_vec[4] = (s64_out   != s64_in);
    mism_vec[5] = (s65_out   != s65_in);
    mism_vec[6] = (s129_out  != s129_in);
    mism_vec[7] = (s4x32_out != s4x32_in);
    // The accumulator has no defined history before the first RUN cycle.
    mism_vec[8] = (run_idx_reg != 16'd0) &&
                  (accum_out != prev_out_reg + prev_in_reg + SECRET_VALUE);
    mism_vec[9] = (accum_bypass_out != (accum_bypass_reg ? accum_in_reg : accum_out));
  end

  always_comb begin
    mism_cnt = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      mism_cnt = mism_cnt + {3'b000, mism_vec[i]};
    end
    err_sum        = {1'b0, err_count_reg} + {5'b00000, mism_cnt};
    err_count_next = err_sum[8] ? 8'hff : err_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      crc_reg          <= '0;
      accum_in_reg     <= '0;
      accum_bypass_reg <= 1'b0;
      run_idx_reg      <= '0;
      prev_out_reg     <= '0;
      prev_in_reg      <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
      err_count_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_SEED;
            busy_reg  <= 1'b1;
          end
        end
        ST_SEED: begin
          crc_reg          <= SEED;
          accum_in_reg     <= ACCUM_BASE;
          accum_bypass_reg <= 1'b0;
          run_idx_reg      <= '0;
          err_reg          <= 1'b0;
          err_count_reg    <= '0;
          state_reg        <= ST_RUN;
        end
        ST_RUN: begin
          crc_reg      <= {crc_reg[62:0], crc_reg[63] ^ crc_reg[2] ^ crc_reg[0]};
          accum_in_reg <= accum_in_reg + ACCUM_STEP;
          run_idx_reg  <= run_idx_reg + 16'd1;
          prev_out_reg <= accum_out;
          prev_in_reg  <= accum_in_reg;
          if (run_idx_reg == BYPASS_IDX) begin
            accum_bypass_reg <= 1'b1;
          end
          err_count_reg <= err_count_next;
          if (mism_cnt != 4'd0) begin
            err_reg <= 1'b1;
          end
          if (run_idx_reg == LAST_IDX) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_reg <= ST_SEED;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
